// File: rtl/ofdm_test_source_if.sv
// Sample and clock bundle produced by the OFDM test source.
// The master drives it and the downstream sorter path receives it.
interface ofdm_test_source_if;
  logic [7:0] out_re;
  logic [7:0] out_im;
  logic [7:0] re_conj;
  logic [7:0] im_conj;
  logic       pll_clk;
  logic       pll_locked;

  modport master (output out_re, out_im, re_conj, im_conj, pll_clk, pll_locked);
  modport slave  (input  out_re, out_im, re_conj, im_conj, pll_clk, pll_locked);
endinterface

// File: rtl/ofdm_test_source.sv
// Complex ramp generator with a zero-latency conjugate, plus a divided "PLL" clock
// and a lock indicator for the downstream sorters.
module ofdm_test_source #(
  parameter logic [7:0] STEP        = 8'd1,
  parameter int         DIV_HALF    = 2,
  parameter int         LOCK_CYCLES = 8,
  parameter bit         SATURATE    = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  ofdm_test_source_if.master  src
);

  localparam int              DW       = $clog2(DIV_HALF) + 1;
  localparam int              LW       = $clog2(LOCK_CYCLES + 1);
  localparam logic [DW-1:0]   DIV_LAST = DW'(DIV_HALF - 1);
  localparam logic [LW-1:0]   LOCK_MAX = LW'(LOCK_CYCLES);

  logic [7:0]    cnt_reg;
  logic [DW-1:0] div_cnt_reg;
  logic          pll_clk_reg;
  logic [LW-1:0] lock_cnt_reg;
  logic [7:0]    im_sample;
  logic [7:0]    im_neg;
  logic [7:0]    im_conj_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg      <= 8'h00;
      div_cnt_reg  <= '0;
      pll_clk_reg  <= 1'b0;
      lock_cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + STEP;
      if (div_cnt_reg == DIV_LAST) begin
        div_cnt_reg <= '0;
        pll_clk_reg <= ~pll_clk_reg;
      end else begin
        div_cnt_reg <= div_cnt_reg + DW'(1);
      end
      // Lock counter parks at its terminal value until the next reset.
      if (lock_cnt_reg != LOCK_MAX) begin
        lock_cnt_reg <= lock_cnt_reg + LW'(1);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_im
      assign im_sample[gi] = ~cnt_reg[gi];
    end
  endgenerate

  assign im_neg = ~im_sample + 8'd1;

  // -128 has no positive counterpart; optionally clamp it to +127.
  always_comb begin
    im_conj_next = im_neg;
    if (im_sample == 8'h80) begin
      im_conj_next = SATURATE ? 8'h7F : 8'h80;
    end
  end

  assign src.out_re     = cnt_reg;
  assign src.out_im     = im_sample;
  assign src.re_conj    = cnt_reg;
  assign src.im_conj    = im_conj_next;
  assign src.pll_clk    = pll_clk_reg;
  assign src.pll_locked = (lock_cnt_reg == LOCK_MAX);

endmodule

// File: tb/tb_ofdm_test_source.sv
// Scoreboard bench: the driver pushes one expectation per clk cycle, the monitor
// pops on the falling edge and compares two differently parameterised instances.
module tb_ofdm_test_source;
  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  ofdm_test_source_if if_a ();
  ofdm_test_source_if if_b ();

  ofdm_test_source #(.STEP(8'd1), .DIV_HALF(2), .LOCK_CYCLES(8), .SATURATE(1'b1)) dut_a (
    .clk(clk), .reset(reset), .src(if_a.master)
  );
  ofdm_test_source #(.STEP(8'd1), .DIV_HALF(1), .LOCK_CYCLES(3), .SATURATE(1'b0)) dut_b (
    .clk(clk), .reset(reset), .src(if_b.master)
  );

  typedef struct {
    logic [7:0] re;
    logic [7:0] im;
    logic [7:0] rc;
    logic [7:0] ic;
    logic       pll;
    logic       lock;
  } exp_t;

  typedef struct {
    int   k;
    exp_t a;
    exp_t b;
  } txn_t;

  // Hand-computed values for instance A (DIV_HALF=2, LOCK_CYCLES=8, SATURATE=1).
  typedef struct {
    int         k;
    logic [7:0] re;
    logic [7:0] im;
    logic [7:0] ic;
    logic       pll;
    logic       lock;
  } dir_t;

  dir_t dir_tab [8] = '{
    '{0,   8'h00, 8'hFF, 8'h01, 1'b0, 1'b0},
    '{1,   8'h01, 8'hFE, 8'h02, 1'b0, 1'b0},
    '{5,   8'h05, 8'hFA, 8'h06, 1'b0, 1'b0},
    '{7,   8'h07, 8'hF8, 8'h08, 1'b1, 1'b0},
    '{8,   8'h08, 8'hF7, 8'h09, 1'b0, 1'b1},
    '{127, 8'h7F, 8'h80, 8'h7F, 1'b1, 1'b1},
    '{128, 8'h80, 8'h7F, 8'h81, 1'b0, 1'b1},
    '{256, 8'h00, 8'hFF, 8'h01, 1'b0, 1'b1}
  };

  txn_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   k = 0;

  // Behaviour as a function of the number of edges seen since reset release.
  function automatic exp_t model(int kk, int step, int div, int lockc, bit sat);
    exp_t e;
    e.re   = 8'((kk * step) % 256);
    e.im   = 8'hFF - e.re;
    e.rc   = e.re;
    if (e.im == 8'h80) e.ic = sat ? 8'h7F : 8'h80;
    else               e.ic = 8'((256 - int'(e.im)) % 256);
    e.pll  = ((kk / div) % 2) == 1;
    e.lock = kk >= lockc;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push();
    txn_t t;
    t.k = k;
    t.a = model(k, 1, 2, 8, 1'b1);
    t.b = model(k, 1, 1, 3, 1'b0);
    q.push_back(t);
  endtask

  task automatic tick(input bit rst_val);
    @(posedge clk);
    if (!reset) k++;
    #1 reset = rst_val;
    if (rst_val) k = 0;
    push();
  endtask

  // Reset pulse entirely between two edges: only an asynchronous clear shows it.
  task automatic pulse();
    @(posedge clk);
    if (!reset) k++;
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    k = 0;
    push();
  endtask

  initial begin : monitor
    txn_t t;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        t = q.pop_front();
        $display("txn k=%0d a: re=%02h im=%02h rc=%02h ic=%02h pll=%0b lock=%0b | b: ic=%02h pll=%0b lock=%0b",
                 t.k, if_a.out_re, if_a.out_im, if_a.re_conj, if_a.im_conj, if_a.pll_clk,
                 if_a.pll_locked, if_b.im_conj, if_b.pll_clk, if_b.pll_locked);
        chk("a_out_re",  32'(if_a.out_re),     32'(t.a.re));
        chk("a_out_im",  32'(if_a.out_im),     32'(t.a.im));
        chk("a_re_conj", 32'(if_a.re_conj),    32'(t.a.rc));
        chk("a_im_conj", 32'(if_a.im_conj),    32'(t.a.ic));
        chk("a_pll_clk", 32'(if_a.pll_clk),    32'(t.a.pll));
        chk("a_locked",  32'(if_a.pll_locked), 32'(t.a.lock));
        chk("b_out_re",  32'(if_b.out_re),     32'(t.b.re));
        chk("b_im_conj", 32'(if_b.im_conj),    32'(t.b.ic));
        chk("b_pll_clk", 32'(if_b.pll_clk),    32'(t.b.pll));
        chk("b_locked",  32'(if_b.pll_locked), 32'(t.b.lock));
        for (int i = 0; i < 8; i++) begin
          if (dir_tab[i].k == t.k) begin
            chk("dir_out_re",  32'(if_a.out_re),     32'(dir_tab[i].re));
            chk("dir_out_im",  32'(if_a.out_im),     32'(dir_tab[i].im));
            chk("dir_re_conj", 32'(if_a.re_conj),    32'(dir_tab[i].re));
            chk("dir_im_conj", 32'(if_a.im_conj),    32'(dir_tab[i].ic));
            chk("dir_pll_clk", 32'(if_a.pll_clk),    32'(dir_tab[i].pll));
            chk("dir_locked",  32'(if_a.pll_locked), 32'(dir_tab[i].lock));
          end
        end
      end
    end
  end

  initial begin : driver
    bit drained;
    repeat (10) tick(1'b1);
    repeat (64) tick(1'b0);
    repeat (3)  tick(1'b1);
    repeat (300) tick(1'b0);
    pulse();
    repeat (12) tick(1'b0);
    drained = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (q.size() == 0) begin
        drained = 1'b1;
        break;
      end
    end
    checks++;
    if (!drained) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
